multicycle_cpu: RTL and testbench

- Parametrised multi-cycle MIPS-subset core with a finite state machine.
- Uses one unified instruction/data memory port with a req/ready handshake, so the memory may insert wait states.
- Adds run/halt control, illegal-instruction detection and a retired-instruction counter.
- Sits between the testbench or SoC top and an external memory model. Memory preload happens outside the core while it is held in IDLE.

---
 rtl/multicycle_cpu_pkg.sv | 41 ++++
 rtl/multicycle_cpu_if.sv | 17 +
 rtl/multicycle_cpu_regfile.sv | 35 +++
 rtl/multicycle_cpu.sv | 188 ++++++++++++++++++
 tb/tb_multicycle_cpu.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_cpu_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset core: FSM states,
// opcode/funct constants, ALU operation selects and the legality decoder.
package multicycle_cpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_PASS_B
  } alu_op_t;

  // HALT (0x3F) is handled separately and is not reported as legal here.
  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_RTYPE: return fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
      OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI,
      OP_ORI, OP_LUI, OP_LW, OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_cpu_if.sv
// Unified instruction/data memory port with a req/ready handshake.
interface multicycle_cpu_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                  input  mem_rdata, mem_ready);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                  output mem_rdata, mem_ready);
endinterface

// File: rtl/multicycle_cpu_regfile.sv
// GPR file: two asynchronous read ports, one synchronous write port,
// r0 and unimplemented indices read as zero, asynchronous active-low clear.
module mc_regfile #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [4:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [4:0]        raddr_a,
  input  logic [4:0]        raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);
  localparam int IDX_W = $clog2(NUM_REGS);

  logic [DATA_W-1:0] regs [NUM_REGS];

  function automatic logic in_range(input logic [4:0] idx);
    return (idx != 5'd0) && (32'(idx) < NUM_REGS);
  endfunction

  assign rdata_a = in_range(raddr_a) ? regs[raddr_a[IDX_W-1:0]] : '0;
  assign rdata_b = in_range(raddr_b) ? regs[raddr_b[IDX_W-1:0]] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && in_range(waddr)) begin
      regs[waddr[IDX_W-1:0]] <= wdata;
    end
  end
endmodule

// File: rtl/multicycle_cpu.sv
// Multi-cycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB sequencer on a
// single wait-stated memory port, with run/halt control and retire counter.
module multicycle_cpu
  import multicycle_cpu_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter int                NUM_REGS = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  multicycle_cpu_if.master   mem,
  output logic               halted,
  output logic               illegal,
  output logic [CNT_W-1:0]   retired,
  output logic [ADDR_W-1:0]  pc_dbg
);
  state_t                   state, state_n;
  logic [ADDR_W-1:0]        pc, target;
  logic [31:0]              ir;
  logic signed [DATA_W-1:0] a_reg, b_reg, alu_b;
  logic [DATA_W-1:0]        alu_out, mdr;
  logic [CNT_W-1:0]         retired_q;
  logic                     illegal_q, retire, set_illegal;
  alu_op_t                  alu_op;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, rf_waddr;
  logic [15:0] imm;
  logic [DATA_W-1:0] rf_rdata_a, rf_rdata_b, rf_wdata;
  logic              rf_we, br_taken;
  logic [ADDR_W-1:0] br_off, jump_target;

  assign opcode = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign funct  = ir[5:0];
  assign imm    = ir[15:0];

  assign br_off      = ADDR_W'(signed'({imm, 2'b00}));
  // Keep PC bits above 27 (if any) and splice in the 26-bit word index.
  assign jump_target = (pc & ~ADDR_W'(28'hFFF_FFFF)) | ADDR_W'({ir[25:0], 2'b00});
  assign br_taken    = (a_reg == b_reg) ^ (opcode == OP_BNE);

  assign rf_waddr = (opcode == OP_RTYPE) ? rd : rt;
  assign rf_wdata = (opcode == OP_LW) ? mdr : alu_out;

  function automatic logic [DATA_W-1:0] alu_fn(input alu_op_t op,
                                                input logic signed [DATA_W-1:0] x,
                                                input logic signed [DATA_W-1:0] y);
    case (op)
      ALU_SUB:    return x - y;
      ALU_AND:    return x & y;
      ALU_OR:     return x | y;
      ALU_SLT:    return (x < y) ? DATA_W'(1) : '0;
      ALU_PASS_B: return y;
      default:    return x + y;
    endcase
  endfunction

  always_comb begin
    alu_op = ALU_ADD;
    alu_b  = DATA_W'(signed'(imm));
    case (opcode)
      OP_RTYPE: begin
        alu_b = b_reg;
        case (funct)
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          default: alu_op = ALU_ADD;
        endcase
      end
      OP_ANDI: begin alu_op = ALU_AND;    alu_b = DATA_W'(imm);          end
      OP_ORI:  begin alu_op = ALU_OR;     alu_b = DATA_W'(imm);          end
      OP_LUI:  begin alu_op = ALU_PASS_B; alu_b = DATA_W'({imm, 16'h0}); end
      default: ;
    endcase
  end

  mc_regfile #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_rf (
    .clk(clk), .rst(rst), .we(rf_we), .waddr(rf_waddr), .wdata(rf_wdata),
    .raddr_a(rs), .raddr_b(rt), .rdata_a(rf_rdata_a), .rdata_b(rf_rdata_b)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  // Memory outputs decode straight from held registers, so they stay stable across waits.
  always_comb begin
    state_n       = state;
    retire        = 1'b0;
    set_illegal   = 1'b0;
    rf_we         = 1'b0;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    case (state)
      S_IDLE: if (run) state_n = S_FETCH;
      S_FETCH: begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = pc;
        if (mem.mem_ready) state_n = S_DECODE;
      end
      S_DECODE: begin
        if (opcode == OP_HALT) begin
          retire  = 1'b1;
          state_n = S_HALT;
        end else if (!is_legal(opcode, funct)) begin
          set_illegal = 1'b1;
          state_n     = S_HALT;
        end else begin
          state_n = S_EXEC;
        end
      end
      S_EXEC: begin
        case (opcode)
          OP_LW, OP_SW:         state_n = S_MEM;
          OP_BEQ, OP_BNE, OP_J: begin retire = 1'b1; state_n = S_FETCH; end
          default:              state_n = S_WB;
        endcase
      end
      S_MEM: begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = alu_out[ADDR_W-1:0];
        if (opcode == OP_SW) begin
          mem.mem_we    = 1'b1;
          mem.mem_wdata = b_reg;
        end
        if (mem.mem_ready) begin
          retire  = (opcode == OP_SW);
          state_n = (opcode == OP_SW) ? S_FETCH : S_WB;
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        retire  = 1'b1;
        state_n = S_FETCH;
      end
      default: state_n = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc        <= RESET_PC;
      ir        <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      target    <= '0;
      alu_out   <= '0;
      mdr       <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      if (state == S_FETCH && mem.mem_ready) begin
        ir <= mem.mem_rdata[31:0];
        pc <= pc + ADDR_W'(4);
      end
      if (state == S_DECODE) begin
        a_reg  <= rf_rdata_a;
        b_reg  <= rf_rdata_b;
        target <= pc + br_off;
      end
      if (state == S_EXEC) begin
        alu_out <= alu_fn(alu_op, a_reg, alu_b);
        if (opcode == OP_J)                                         pc <= jump_target;
        else if ((opcode == OP_BEQ || opcode == OP_BNE) && br_taken) pc <= target;
      end
      if (state == S_MEM && mem.mem_ready && opcode == OP_LW) mdr <= mem.mem_rdata;
      if (retire)      retired_q <= retired_q + CNT_W'(1);
      if (set_illegal) illegal_q <= 1'b1;
    end
  end

  assign halted  = (state == S_HALT);
  assign illegal = illegal_q;
  assign retired = retired_q;
  assign pc_dbg  = pc;
endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed bench for multicycle_cpu: word-addressed memory models with
// programmable wait states and hand-assembled programs.
module tb_multicycle_cpu;
  logic        clk = 1'b0, rst_n = 1'b1, run = 1'b0, run8 = 1'b0;
  logic        halted, illegal, halted8, illegal8;
  logic [31:0] retired, pc_dbg, retired8, pc_dbg8;
  int          n_chk = 0, n_pass = 0;
  int          wait_n = 0, wcnt0 = 0;
  logic        ld_en = 1'b0, ld_sel = 1'b0;
  logic [9:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic [31:0] mem0 [1024];
  logic [31:0] mem8 [1024];

  multicycle_cpu_if #(.DATA_W(32), .ADDR_W(32)) m0 ();
  multicycle_cpu_if #(.DATA_W(32), .ADDR_W(32)) m8 ();

  always #5 clk = ~clk;

  multicycle_cpu #(.DATA_W(32), .ADDR_W(32), .NUM_REGS(32), .RESET_PC(32'h0), .CNT_W(32)) dut (
    .clk(clk), .rst(rst_n), .run(run), .mem(m0), .halted(halted), .illegal(illegal),
    .retired(retired), .pc_dbg(pc_dbg));

  multicycle_cpu #(.DATA_W(32), .ADDR_W(32), .NUM_REGS(8), .RESET_PC(32'h0), .CNT_W(32)) dut8 (
    .clk(clk), .rst(rst_n), .run(run8), .mem(m8), .halted(halted8), .illegal(illegal8),
    .retired(retired8), .pc_dbg(pc_dbg8));

  assign m0.mem_ready = m0.mem_req && (wcnt0 == wait_n);
  assign m0.mem_rdata = mem0[m0.mem_addr[11:2]];
  assign m8.mem_ready = m8.mem_req;
  assign m8.mem_rdata = mem8[m8.mem_addr[11:2]];

  always @(posedge clk) begin
    if (ld_en && !ld_sel) mem0[ld_addr] <= ld_data;
    if (ld_en && ld_sel)  mem8[ld_addr] <= ld_data;
    if (m0.mem_req && m0.mem_ready && m0.mem_we) mem0[m0.mem_addr[11:2]] <= m0.mem_wdata;
    if (m8.mem_req && m8.mem_ready && m8.mem_we) mem8[m8.mem_addr[11:2]] <= m8.mem_wdata;
    wcnt0 <= (m0.mem_req && !m0.mem_ready) ? wcnt0 + 1 : 0;
  end

  task automatic load(input logic sel, input int waddr, input logic [31:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_sel = sel; ld_addr = waddr[9:0]; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; run = 1'b0; run8 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      run = 1'b0; run8 = 1'b0;
    end
  endtask

  task automatic run_main(input int budget, output int cyc);
    @(negedge clk);
    run = 1'b1; cyc = 0;
    while (cyc < budget && !halted) begin step(1); cyc++; end
  endtask

  task automatic test_reset();
    @(negedge clk); rst_n = 1'b0; #1;
    n_chk++; if (m0.mem_req !== 1'b0) $display("FAIL rst_req_async: got %b want 0", m0.mem_req); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    n_chk++; if (halted !== 1'b0) $display("FAIL rst_halted: got %b want 0", halted); else n_pass++;
    n_chk++; if (illegal !== 1'b0) $display("FAIL rst_illegal: got %b want 0", illegal); else n_pass++;
    n_chk++; if (retired !== 32'd0) $display("FAIL rst_retired: got %0d want 0", retired); else n_pass++;
    n_chk++; if (pc_dbg !== 32'h0) $display("FAIL rst_pc: got %h want 0", pc_dbg); else n_pass++;
    n_chk++; if ({m0.mem_we, m0.mem_addr, m0.mem_wdata} !== 65'h0)
      $display("FAIL rst_bus: got we=%b addr=%h wdata=%h want all 0", m0.mem_we, m0.mem_addr, m0.mem_wdata); else n_pass++;
    step(4);
    n_chk++; if (m0.mem_req !== 1'b0) $display("FAIL idle_no_req: got %b want 0", m0.mem_req); else n_pass++;
  endtask

  task automatic test_alu();
    int cyc;
    do_reset();
    load(0, 0, 32'h20010005); load(0, 1, 32'h2002FFFD); load(0, 2, 32'h00221820);
    load(0, 3, 32'h0041202A); load(0, 4, 32'hFC000000);
    run_main(100, cyc);
    n_chk++; if (cyc !== 19) $display("FAIL alu_cycles: got %0d want 19", cyc); else n_pass++;
    n_chk++; if (halted !== 1'b1 || illegal !== 1'b0) $display("FAIL alu_halt: got halted=%b illegal=%b want 1/0", halted, illegal); else n_pass++;
    n_chk++; if (retired !== 32'd5) $display("FAIL alu_retired: got %0d want 5", retired); else n_pass++;
    n_chk++; if (dut.u_rf.regs[2] !== 32'hFFFFFFFD) $display("FAIL alu_r2: got %h want fffffffd", dut.u_rf.regs[2]); else n_pass++;
    n_chk++; if (dut.u_rf.regs[3] !== 32'd2) $display("FAIL alu_add_r3: got %h want 2", dut.u_rf.regs[3]); else n_pass++;
    n_chk++; if (dut.u_rf.regs[4] !== 32'd1) $display("FAIL alu_slt_r4: got %h want 1", dut.u_rf.regs[4]); else n_pass++;
  endtask

  task automatic test_mem();
    int cyc = 0, wr_cnt = 0;
    logic prev_req = 1'b0, prev_rdy = 1'b0, c_we = 1'b0;
    logic [31:0] c_addr = '0, c_wdata = '0, wr_addr = '0, wr_data = '0;
    do_reset();
    load(0, 0, 32'h3C011234); load(0, 1, 32'h34215678); load(0, 2, 32'hAC010040);
    load(0, 3, 32'h8C050040); load(0, 4, 32'hFC000000); load(0, 16, 32'h0);
    wait_n = 3;
    @(negedge clk); run = 1'b1;
    while (cyc < 400 && !halted) begin
      step(1); cyc++;
      if (m0.mem_req) begin
        if (prev_req && !prev_rdy) begin
          n_chk++; if (m0.mem_addr !== c_addr) $display("FAIL wait_addr: got %h want %h", m0.mem_addr, c_addr); else n_pass++;
          n_chk++; if (m0.mem_we !== c_we) $display("FAIL wait_we: got %b want %b", m0.mem_we, c_we); else n_pass++;
          n_chk++; if (m0.mem_wdata !== c_wdata) $display("FAIL wait_wdata: got %h want %h", m0.mem_wdata, c_wdata); else n_pass++;
        end else begin
          c_addr = m0.mem_addr; c_we = m0.mem_we; c_wdata = m0.mem_wdata;
        end
        if (m0.mem_ready && m0.mem_we) begin wr_cnt++; wr_addr = m0.mem_addr; wr_data = m0.mem_wdata; end
      end
      prev_req = m0.mem_req; prev_rdy = m0.mem_ready;
    end
    wait_n = 0;
    n_chk++; if (cyc !== 41) $display("FAIL mem_cycles: got %0d want 41", cyc); else n_pass++;
    n_chk++; if (wr_cnt !== 1 || wr_addr !== 32'h40) $display("FAIL sw_addr: got n=%0d addr=%h want 1 @40", wr_cnt, wr_addr); else n_pass++;
    n_chk++; if (wr_data !== 32'h12345678) $display("FAIL sw_data: got %h want 12345678", wr_data); else n_pass++;
    n_chk++; if (mem0[16] !== 32'h12345678) $display("FAIL sw_mem: got %h want 12345678", mem0[16]); else n_pass++;
    n_chk++; if (dut.u_rf.regs[5] !== 32'h12345678) $display("FAIL lw_r5: got %h want 12345678", dut.u_rf.regs[5]); else n_pass++;
    n_chk++; if (retired !== 32'd5) $display("FAIL mem_retired: got %0d want 5", retired); else n_pass++;
  endtask

  task automatic test_branch();
    do_reset();
    load(0, 0, 32'h10000002); load(0, 1, 32'h20060001); load(0, 2, 32'h20060002);
    load(0, 3, 32'h20010003); load(0, 4, 32'h14210005); load(0, 5, 32'h08000100);
    load(0, 256, 32'hFC000000);
    @(negedge clk); run = 1'b1;
    step(4);
    n_chk++; if (pc_dbg !== 32'h0C) $display("FAIL beq_taken_pc: got %h want 0c", pc_dbg); else n_pass++;
    step(4);
    n_chk++; if (pc_dbg !== 32'h10) $display("FAIL addi_pc: got %h want 10", pc_dbg); else n_pass++;
    step(3);
    n_chk++; if (pc_dbg !== 32'h14) $display("FAIL bne_fallthru_pc: got %h want 14", pc_dbg); else n_pass++;
    step(3);
    n_chk++; if (pc_dbg !== 32'h400 || halted !== 1'b0) $display("FAIL j_pc: got %h halted=%b want 400/0", pc_dbg, halted); else n_pass++;
    step(2);
    n_chk++; if (halted !== 1'b1 || pc_dbg !== 32'h404) $display("FAIL br_halt: got halted=%b pc=%h want 1/404", halted, pc_dbg); else n_pass++;
    n_chk++; if (retired !== 32'd5) $display("FAIL br_retired: got %0d want 5", retired); else n_pass++;
    n_chk++; if (dut.u_rf.regs[6] !== 32'd0 || dut.u_rf.regs[1] !== 32'd3)
      $display("FAIL br_regs: got r6=%h r1=%h want 0/3", dut.u_rf.regs[6], dut.u_rf.regs[1]); else n_pass++;
  endtask

  task automatic test_illegal();
    int cyc;
    do_reset();
    n_chk++; if (illegal !== 1'b0) $display("FAIL ill_clear: got %b want 0", illegal); else n_pass++;
    load(0, 0, 32'h20010001); load(0, 1, 32'hF8000000);
    run_main(50, cyc);
    n_chk++; if (cyc !== 7) $display("FAIL ill_cycles: got %0d want 7", cyc); else n_pass++;
    n_chk++; if (halted !== 1'b1 || illegal !== 1'b1) $display("FAIL ill_op: got halted=%b illegal=%b want 1/1", halted, illegal); else n_pass++;
    n_chk++; if (retired !== 32'd1) $display("FAIL ill_retired: got %0d want 1", retired); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); run = ~run;
      @(posedge clk); #1;
      n_chk++; if (m0.mem_req !== 1'b0 || halted !== 1'b1) $display("FAIL ill_absorb: got req=%b halted=%b want 0/1", m0.mem_req, halted); else n_pass++;
    end
    n_chk++; if (retired !== 32'd1 || pc_dbg !== 32'h8) $display("FAIL ill_frozen: got ret=%0d pc=%h want 1/8", retired, pc_dbg); else n_pass++;
    do_reset();
    load(0, 0, 32'h00000021);
    run_main(50, cyc);
    n_chk++; if (cyc !== 3 || illegal !== 1'b1 || retired !== 32'd0)
      $display("FAIL ill_funct: got cyc=%0d illegal=%b ret=%0d want 3/1/0", cyc, illegal, retired); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int cyc, bad = 0;
    do_reset();
    load(0, 0, 32'h20010009); load(0, 1, 32'h8C020040); load(0, 2, 32'hFC000000);
    load(0, 16, 32'hCAFEF00D);
    @(negedge clk); run = 1'b1;
    step(5);
    wait_n = 50;
    step(3);
    n_chk++; if (m0.mem_req !== 1'b1 || m0.mem_addr !== 32'h4) $display("FAIL mid_waiting: got req=%b addr=%h want 1/4", m0.mem_req, m0.mem_addr); else n_pass++;
    n_chk++; if (retired !== 32'd1 || dut.u_rf.regs[1] !== 32'd9) $display("FAIL mid_pre: got ret=%0d r1=%h want 1/9", retired, dut.u_rf.regs[1]); else n_pass++;
    rst_n = 1'b0; #1;
    n_chk++; if (m0.mem_req !== 1'b0) $display("FAIL mid_req_drop: got %b want 0", m0.mem_req); else n_pass++;
    n_chk++; if (pc_dbg !== 32'h0 || retired !== 32'd0) $display("FAIL mid_pc_ret: got pc=%h ret=%0d want 0/0", pc_dbg, retired); else n_pass++;
    for (int i = 0; i < 32; i++) if (dut.u_rf.regs[i] !== 32'd0) bad++;
    n_chk++; if (bad !== 0) $display("FAIL mid_gpr_clear: got %0d nonzero want 0", bad); else n_pass++;
    @(negedge clk); rst_n = 1'b1; wait_n = 0;
    step(5);
    n_chk++; if (m0.mem_req !== 1'b0 || pc_dbg !== 32'h0) $display("FAIL mid_stay_idle: got req=%b pc=%h want 0/0", m0.mem_req, pc_dbg); else n_pass++;
    run_main(100, cyc);
    n_chk++; if (cyc !== 12 || retired !== 32'd3) $display("FAIL mid_rerun: got cyc=%0d ret=%0d want 12/3", cyc, retired); else n_pass++;
    n_chk++; if (dut.u_rf.regs[2] !== 32'hCAFEF00D) $display("FAIL mid_lw: got %h want cafef00d", dut.u_rf.regs[2]); else n_pass++;
  endtask

  task automatic test_r0_numregs();
    int cyc = 0;
    do_reset();
    load(0, 0, 32'h20010004); load(0, 1, 32'h20000007); load(0, 2, 32'h00000820); load(0, 3, 32'hFC000000);
    run_main(100, cyc);
    n_chk++; if (dut.u_rf.regs[1] !== 32'd0 || dut.u_rf.regs[0] !== 32'd0)
      $display("FAIL r0_hardwired: got r1=%h r0=%h want 0/0", dut.u_rf.regs[1], dut.u_rf.regs[0]); else n_pass++;
    n_chk++; if (retired !== 32'd4) $display("FAIL r0_retired: got %0d want 4", retired); else n_pass++;
    load(1, 0, 32'h20010006); load(1, 1, 32'h20090005); load(1, 2, 32'h01201020);
    load(1, 3, 32'hAC010080); load(1, 4, 32'hAC020084); load(1, 5, 32'hFC000000);
    load(1, 32, 32'hFFFFFFFF); load(1, 33, 32'hFFFFFFFF);
    @(negedge clk); run8 = 1'b1; cyc = 0;
    while (cyc < 200 && !halted8) begin step(1); cyc++; end
    n_chk++; if (halted8 !== 1'b1 || illegal8 !== 1'b0 || pc_dbg8 !== 32'h18)
      $display("FAIL n8_halt: got halted=%b illegal=%b pc=%h want 1/0/18", halted8, illegal8, pc_dbg8); else n_pass++;
    n_chk++; if (mem8[32] !== 32'd6) $display("FAIL n8_r1_intact: got %h want 6", mem8[32]); else n_pass++;
    n_chk++; if (mem8[33] !== 32'd0) $display("FAIL n8_r9_reads0: got %h want 0", mem8[33]); else n_pass++;
    n_chk++; if (retired8 !== 32'd6) $display("FAIL n8_retired: got %0d want 6", retired8); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_illegal();
    test_reset_mid();
    test_r0_numregs();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
